// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job controller: FSM state encoding and default widths.
package rsa_pkg;

  localparam int unsigned BaseWidthDef = 4;
  localparam int unsigned ExpoWidthDef = 4;
  localparam int unsigned NWidthDef    = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StGuard = 3'd2,
    StWait  = 3'd3,
    StHold  = 3'd4
  } rsa_state_e;

endpackage

// File: rtl/rsa_timeout_cntr.sv
// WAIT-state cycle counter; expired_o flags the cycle on which the limit is reached.
module rsa_timeout_cntr #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // cnt_q counts completed WAIT cycles, so the current cycle is number cnt_q + 1
  assign expired_o = en_i && (({1'b0, cnt_q} + {{Width{1'b0}}, 1'b1}) >= {1'b0, limit_i});

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rsa_job_ctrl.sv
// Single-job sequencer around a modular-exponentiation core.
// Optional WAIT timeout is enabled by defining RSA_JOB_TIMEOUT_EN.
module rsa_job_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned base_width  = BaseWidthDef,
  parameter int unsigned expo_width  = ExpoWidthDef,
  parameter int unsigned N_width     = NWidthDef,
  parameter int unsigned TIMEOUT_CYC = 2**expo_width + 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [base_width-1:0] in_base,
  input  logic [expo_width-1:0] in_expo,
  input  logic [N_width-1:0]    in_N,
  output logic                  core_start,
  output logic [base_width-1:0] core_base,
  output logic [expo_width-1:0] core_expo,
  output logic [N_width-1:0]    core_N,
  input  logic [N_width-1:0]    core_result,
  input  logic                  core_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_width-1:0]    out_result,
  output logic                  out_err,
  output logic                  busy
);

  rsa_state_e            state_q, state_d;
  logic                  rdy_q;
  logic [base_width-1:0] base_q;
  logic [expo_width-1:0] expo_q;
  logic [N_width-1:0]    n_q;
  logic [N_width-1:0]    result_q, result_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  tmo_expired;

  // rdy_q keeps in_ready low until the first edge after reset release
  assign in_ready   = rdy_q && (state_q == StIdle);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != StIdle);
  assign core_start = (state_q == StStart);
  assign out_valid  = (state_q == StHold);
  assign core_base  = base_q;
  assign core_expo  = expo_q;
  assign core_N     = n_q;
  assign out_result = result_q;
  assign out_err    = err_q;

`ifdef RSA_JOB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  rsa_timeout_cntr #(
    .Width(CntW)
  ) u_timeout_cntr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q == StGuard),
    .en_i     (state_q == StWait),
    .limit_i  (CntW'(TIMEOUT_CYC)),
    .expired_o(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_N == '0) begin
            state_d  = StHold;
            result_d = '0;
            err_d    = 1'b1;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: state_d = StGuard;
      // core_valid may still be the previous job's done level here
      StGuard: state_d = StWait;
      StWait: begin
        if (core_valid) begin
          state_d  = StHold;
          result_d = core_result;
          err_d    = 1'b0;
        end else if (tmo_expired) begin
          state_d  = StHold;
          result_d = '0;
          err_d    = 1'b1;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rdy_q    <= 1'b0;
      base_q   <= '0;
      expo_q   <= '0;
      n_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= 1'b1;
      result_q <= result_d;
      err_q    <= err_d;
      if (accept) begin
        base_q <= in_base;
        expo_q <= in_expo;
        n_q    <= in_N;
      end
    end
  end

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Self-checking bench for rsa_job_ctrl with a behavioural exponentiation core model.
module tb_rsa_job_ctrl;

  localparam int TCYC = 2**4 + 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_base = '0, in_expo = '0, in_N = '0;
  logic       core_start;
  logic [3:0] core_base, core_expo, core_N;
  logic [3:0] core_result;
  logic       core_valid;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_result;
  logic       out_err;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;
  int start_cnt = 0;
  bit core_en = 1'b1;

  rsa_job_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_base    (in_base),
    .in_expo    (in_expo),
    .in_N       (in_N),
    .core_start (core_start),
    .core_base  (core_base),
    .core_expo  (core_expo),
    .core_N     (core_N),
    .core_result(core_result),
    .core_valid (core_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic int modpow(int b, int e, int n);
    int r;
    if (n == 0) return 0;
    r = 1 % n;
    for (int i = 0; i < e; i++) r = (r * b) % n;
    return r;
  endfunction

  function automatic int core_lat(int e);
    return (e == 0) ? 1 : e + 2;
  endfunction

  // Core model: done is a level that drops one cycle after a new start and
  // rises core_lat cycles after that; result is garbage while not done.
  int ccnt, clat, cres;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_valid  <= 1'b0;
      core_result <= '0;
      ccnt        <= 0;
      clat        <= 0;
      cres        <= 0;
    end else if (core_start && core_en) begin
      clat <= core_lat(int'(core_expo));
      ccnt <= core_lat(int'(core_expo)) + 1;
      cres <= modpow(int'(core_base), int'(core_expo), int'(core_N));
    end else if (ccnt != 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == clat + 1) core_valid <= 1'b0;
      if (ccnt == 1) begin
        core_valid  <= 1'b1;
        core_result <= 4'(cres);
      end else begin
        core_result <= 4'($urandom);
      end
    end
  end

  always @(posedge clk) if (core_start === 1'b1) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_job(input int b, input int e, input int n, input int hold);
    int k, s0, exp_lat, exp_res, exp_err;
    logic [3:0] res_seen;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    in_base  = 4'(b);
    in_expo  = 4'(e);
    in_N     = 4'(n);
    in_valid = 1'b1;
    s0 = start_cnt;
    @(negedge clk);
    if (n == 0) begin
      exp_lat = 0; exp_res = 0; exp_err = 1;
    end else if (!core_en) begin
      exp_lat = 2 + TCYC; exp_res = 0; exp_err = 1;
    end else begin
      exp_lat = 3 + core_lat(e); exp_res = modpow(b, e, n); exp_err = 0;
    end
    k = 0;
    while (!out_valid && k < 100) begin
      // junk requests and stray out_ready must be ignored while busy
      in_valid  = 1'($urandom);
      in_base   = 4'($urandom);
      in_expo   = 4'($urandom);
      in_N      = 4'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      k++;
    end
    out_ready = 1'b0;
    chk("latency", k, exp_lat);
    chk("out_result", 32'(out_result), exp_res);
    chk("out_err", 32'(out_err), exp_err);
    chk("start_pulses", start_cnt - s0, (n == 0) ? 0 : 1);
    chk("core_ops", {20'd0, core_base, core_expo, core_N}, {20'd0, 4'(b), 4'(e), 4'(n)});
    res_seen = out_result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_N     = 4'($urandom);
      @(negedge clk);
      chk("hold_stable", {out_valid, in_ready, busy, out_result}, {1'b1, 1'b0, 1'b1, res_seen});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_handshake", {out_valid, in_ready, busy}, 3'b010);
    chk("ops_held", {20'd0, core_base, core_expo, core_N}, {20'd0, 4'(b), 4'(e), 4'(n)});
  endtask

  initial begin
    int ov;
    #1;
    chk("rst_outputs", {in_ready, busy, out_valid, out_err, core_start, out_result, core_base},
        '0);
    repeat (2) @(negedge clk);
    chk("rst_ready_low", 32'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 1);

    do_job(3, 4, 7, 3);
    do_job(2, 0, 5, 1);
    do_job(9, 0, 1, 2);
    do_job(5, 3, 0, 1);
    do_job(6, 7, 13, 10);
    for (int j = 0; j < 8; j++) begin
      do_job(int'($urandom_range(15)), int'($urandom_range(15)),
             ($urandom_range(5) == 0) ? 0 : int'($urandom_range(15, 1)),
             int'($urandom_range(4)));
    end

    // reset during WAIT discards the job
    @(negedge clk);
    in_base = 4'd7; in_expo = 4'd15; in_N = 4'd11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("in_wait_busy", {busy, out_valid}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {in_ready, busy, out_valid, out_err, core_start, out_result, core_base},
        '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_rst", {in_ready, busy}, 2'b10);
    ov = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov++;
    end
    chk("no_out_after_rst", ov, 0);
    do_job(3, 4, 7, 0);

`ifdef RSA_JOB_TIMEOUT_EN
    core_en = 1'b0;
    do_job(4, 2, 9, 1);
    core_en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
